// File: rtl/vga_bounce_gen_if.sv
// VGA pin bundle: 4-bit-per-channel RGB plus active-low syncs.
interface vga_bounce_gen_if;
  logic r0, r1, r2, r3;
  logic g0, g1, g2, g3;
  logic b0, b1, b2, b3;
  logic hs, vs;

  modport master (output r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3, hs, vs);
  modport slave  (input  r0, r1, r2, r3, g0, g1, g2, g3, b0, b1, b2, b3, hs, vs);
endinterface

// File: rtl/vga_bounce_gen.sv
// 640x480@60 VGA timing generator drawing a bordered frame and a bouncing square ball.
module vga_bounce_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int BALL   = 16
) (
  input  logic clk,
  input  logic rst,
  vga_bounce_gen_if.master vga
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_MAX  = 10'(H_TOT - 1);
  localparam logic [9:0]  V_MAX  = 10'(V_TOT - 1);
  localparam logic [9:0]  H_VISW = 10'(H_VIS);
  localparam logic [9:0]  V_VISW = 10'(V_VIS);
  localparam logic [9:0]  H_LAST = 10'(H_VIS - 1);
  localparam logic [9:0]  V_LAST = 10'(V_VIS - 1);
  localparam logic [9:0]  HS_ON  = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_OFF = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_ON  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_OFF = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0]  H_LIM  = 10'(H_VIS - BALL);
  localparam logic [9:0]  V_LIM  = 10'(V_VIS - BALL);
  localparam logic [9:0]  H_RST  = 10'((H_VIS - BALL) / 2);
  localparam logic [9:0]  V_RST  = 10'((V_VIS - BALL) / 2);
  localparam logic [10:0] BALLW  = 11'(BALL);

  logic [9:0]  count_h, count_v;
  logic [9:0]  ball_pos_h, ball_pos_v;
  logic [9:0]  nxt_h, nxt_v;
  logic        dir_h, dir_v;
  logic        h_wrap, upd;
  logic        blank, in_ball, border, wht;
  logic [11:0] rgb;

  assign h_wrap = (count_h == H_MAX);
  // Ball moves once per frame at the start of vertical blank, so it is never drawn mid-move.
  assign upd    = (count_h == 10'd0) && (count_v == V_VISW);
  assign nxt_h  = dir_h ? ball_pos_h + 10'd1 : ball_pos_h - 10'd1;
  assign nxt_v  = dir_v ? ball_pos_v + 10'd1 : ball_pos_v - 10'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_h    <= '0;
      count_v    <= '0;
      ball_pos_h <= H_RST;
      ball_pos_v <= V_RST;
      dir_h      <= 1'b1;
      dir_v      <= 1'b1;
    end else begin
      count_h <= h_wrap ? 10'd0 : count_h + 10'd1;
      if (h_wrap)
        count_v <= (count_v == V_MAX) ? 10'd0 : count_v + 10'd1;
      if (upd) begin
        ball_pos_h <= nxt_h;
        ball_pos_v <= nxt_v;
        if (dir_h && nxt_h == H_LIM)       dir_h <= 1'b0;
        else if (!dir_h && nxt_h == 10'd0) dir_h <= 1'b1;
        if (dir_v && nxt_v == V_LIM)       dir_v <= 1'b0;
        else if (!dir_v && nxt_v == 10'd0) dir_v <= 1'b1;
      end
    end
  end

  always_comb begin
    blank   = (count_h >= H_VISW) || (count_v >= V_VISW);
    in_ball = ({1'b0, count_h} >= {1'b0, ball_pos_h}) &&
              ({1'b0, count_h} <  {1'b0, ball_pos_h} + BALLW) &&
              ({1'b0, count_v} >= {1'b0, ball_pos_v}) &&
              ({1'b0, count_v} <  {1'b0, ball_pos_v} + BALLW);
    border  = !blank && (count_h == 10'd0 || count_h == H_LAST ||
                         count_v == 10'd0 || count_v == V_LAST);
    wht     = !blank && (in_ball || border);
    rgb     = 12'h004;
    if (rst || blank) rgb = 12'h000;
    else if (wht)     rgb = 12'hFFF;
  end

  assign {vga.r3, vga.r2, vga.r1, vga.r0} = rgb[11:8];
  assign {vga.g3, vga.g2, vga.g1, vga.g0} = rgb[7:4];
  assign {vga.b3, vga.b2, vga.b1, vga.b0} = rgb[3:0];
  assign vga.hs = rst || !(count_h >= HS_ON && count_h <= HS_OFF);
  assign vga.vs = rst || !(count_v >= VS_ON && count_v <= VS_OFF);
endmodule

// File: tb/tb_vga_bounce_gen.sv
// Directed checks: full-size DUT for reset/line timing, a shrunken DUT for frame, bounce and mid-frame reset.
module tb_vga_bounce_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_bounce_gen_if s_if ();
  vga_bounce_gen_if f_if ();

  // Small geometry: 48 clocks/line, 31 lines/frame, ball 8, limits 24/16, reset ball (12,8).
  vga_bounce_gen #(
    .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(3), .BALL(8)
  ) dut (.clk(clk), .rst(rst), .vga(s_if.master));

  vga_bounce_gen dut_f (.clk(clk), .rst(rst), .vga(f_if.master));

  localparam int SH = 48;
  localparam int SV = 31;
  localparam int SF = SH * SV;

  function automatic logic [11:0] col_s();
    return {s_if.r3, s_if.r2, s_if.r1, s_if.r0, s_if.g3, s_if.g2, s_if.g1, s_if.g0,
            s_if.b3, s_if.b2, s_if.b1, s_if.b0};
  endfunction

  function automatic logic [11:0] col_f();
    return {f_if.r3, f_if.r2, f_if.r1, f_if.r0, f_if.g3, f_if.g2, f_if.g1, f_if.g0,
            f_if.b3, f_if.b2, f_if.b1, f_if.b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-picked pixels for small DUT frame 0: h, v, expected colour.
  int          ph [11] = '{0, 5, 12, 19, 20, 11, 15, 31, 5, 40, 5};
  int          pv [11] = '{0, 5,  8, 15, 12, 12, 16,  5, 23, 5, 25};
  logic [11:0] pc [11] = '{12'hFFF, 12'h004, 12'hFFF, 12'hFFF, 12'h004, 12'h004,
                           12'h004, 12'hFFF, 12'hFFF, 12'h000, 12'h000};

  initial begin
    int hs_lo, hs_first, blk_bad;
    int vs_lo, vs_first, hs_fall, oob;
    logic hs_prev;

    repeat (3) @(negedge clk);
    #1;
    check("rst_col_f", 32'(col_f()), 32'h0);
    check("rst_hs_f", 32'(f_if.hs), 32'd1);
    check("rst_vs_f", 32'(f_if.vs), 32'd1);
    check("rst_col_s", 32'(col_s()), 32'h0);
    check("rst_bh_f", 32'(dut_f.ball_pos_h), 32'd312);
    check("rst_bv_f", 32'(dut_f.ball_pos_v), 32'd232);
    check("rst_dir_f", 32'({dut_f.dir_h, dut_f.dir_v}), 32'd3);
    check("rst_bh_s", 32'(dut.ball_pos_h), 32'd12);
    check("rst_bv_s", 32'(dut.ball_pos_v), 32'd8);

    // One full line on the full-size DUT.
    rst = 1'b0;
    #1;
    hs_lo = 0; hs_first = -1; blk_bad = 0;
    for (int t = 0; t <= 800; t++) begin
      if (t == 0)   check("px00_f", 32'(col_f()), 32'hFFF);
      if (t == 100) check("top_border_f", 32'(col_f()), 32'hFFF);
      if (t == 639) check("px639_f", 32'(col_f()), 32'hFFF);
      if (t >= 640 && t < 800 && col_f() != 12'h000) blk_bad++;
      if (t < 800 && !f_if.hs) begin
        if (hs_lo == 0) hs_first = t;
        hs_lo++;
      end
      if (t == 800) begin
        check("wrap_h_f", 32'(dut_f.count_h), 32'd0);
        check("wrap_v_f", 32'(dut_f.count_v), 32'd1);
      end else begin
        @(negedge clk);
        #1;
      end
    end
    check("hs_width_f", 32'(hs_lo), 32'd96);
    check("hs_start_f", 32'(hs_first), 32'd656);
    check("hblank_col_f", 32'(blk_bad), 32'd0);

    // One full frame on the small DUT.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vs_lo = 0; vs_first = -1; hs_fall = 0; hs_prev = 1'b1;
    for (int t = 0; t <= SF; t++) begin
      if (t < SF) begin
        for (int i = 0; i < 11; i++)
          if (t == pv[i] * SH + ph[i])
            check($sformatf("pix_%0d_%0d", ph[i], pv[i]), 32'(col_s()), 32'(pc[i]));
        if (!s_if.vs) begin
          if (vs_lo == 0) vs_first = t;
          vs_lo++;
        end
        if (hs_prev && !s_if.hs) hs_fall++;
        hs_prev = s_if.hs;
        @(negedge clk);
        #1;
      end else begin
        check("frame_h_s", 32'(dut.count_h), 32'd0);
        check("frame_v_s", 32'(dut.count_v), 32'd0);
        check("upd1_h_s", 32'(dut.ball_pos_h), 32'd13);
        check("upd1_v_s", 32'(dut.ball_pos_v), 32'd9);
      end
    end
    check("vs_width_s", 32'(vs_lo), 32'd96);
    check("vs_start_s", 32'(vs_first), 32'd1248);
    check("hs_pulses_s", 32'(hs_fall), 32'd31);

    // Bounce: one update per frame.
    oob = 0;
    for (int k = 2; k <= 26; k++) begin
      repeat (SF) @(negedge clk);
      #1;
      if (dut.ball_pos_h > 10'd24 || dut.ball_pos_v > 10'd16) oob++;
      case (k)
        8: begin
          check("k8_h", 32'(dut.ball_pos_h), 32'd20);
          check("k8_v", 32'(dut.ball_pos_v), 32'd16);
          check("k8_dir", 32'({dut.dir_h, dut.dir_v}), 32'd2);
        end
        12: begin
          check("k12_h", 32'(dut.ball_pos_h), 32'd24);
          check("k12_v", 32'(dut.ball_pos_v), 32'd12);
          check("k12_dir", 32'({dut.dir_h, dut.dir_v}), 32'd0);
        end
        13: begin
          check("k13_h", 32'(dut.ball_pos_h), 32'd23);
          check("k13_v", 32'(dut.ball_pos_v), 32'd11);
        end
        24: begin
          check("k24_h", 32'(dut.ball_pos_h), 32'd12);
          check("k24_v", 32'(dut.ball_pos_v), 32'd0);
          check("k24_dir", 32'({dut.dir_h, dut.dir_v}), 32'd1);
        end
        26: begin
          check("k26_h", 32'(dut.ball_pos_h), 32'd10);
          check("k26_v", 32'(dut.ball_pos_v), 32'd2);
        end
        default: ;
      endcase
    end
    check("ball_in_range", 32'(oob), 32'd0);

    // Mid-frame reset at line 12.
    repeat (12 * SH + 5) @(negedge clk);
    #1;
    check("mid_v_s", 32'(dut.count_v), 32'd12);
    rst = 1'b1;
    #1;
    check("mid_rst_col", 32'(col_s()), 32'h0);
    check("mid_rst_sync", 32'({s_if.hs, s_if.vs}), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_cnt", 32'({dut.count_h, dut.count_v}), 32'd0);
    check("mid_ball_h", 32'(dut.ball_pos_h), 32'd12);
    check("mid_ball_v", 32'(dut.ball_pos_v), 32'd8);
    check("mid_col", 32'(col_s()), 32'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_bounce_gen.md
Name: vga_bounce_gen

Overview:
- Self-contained 640x480@60 Hz VGA timing generator with a bouncing-ball test pattern.
- Drives 4-bit-per-channel RGB plus negative-polarity HSYNC/VSYNC straight to the VGA pins.
- `clk` is the pixel clock, nominally 25.175 MHz; 25 MHz is acceptable.
- Top-level leaf block; no bus interface.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- BALL, 16, ball edge length in pixels (square)

Ports:
- clk  in  1  pixel clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- r0..r3  out  1 each  red, r0 = LSB
- g0..g3  out  1 each  green, g0 = LSB
- b0..b3  out  1 each  blue, b0 = LSB
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Counters:
  - count_h: 10 bits, 0..799 (H total 800).
  - count_v: 10 bits, 0..524 (V total 525).
  - count_h increments every clock and wraps 799->0.
  - count_v increments when count_h wraps; it wraps 524->0 on that same edge.
- Blanking:
  - blank_h = (count_h >= 640).
  - blank_v = (count_v >= 480).
  - blank = blank_h | blank_v.
- Syncs:
  - hs = 0 when 656 <= count_h <= 751, else 1.
  - vs = 0 when 490 <= count_v <= 491, else 1.
- Ball state:
  - ball_pos_h: 10 bits, left edge, range 0..624.
  - ball_pos_v: 10 bits, top edge, range 0..464.
  - dir_h, dir_v: 1 bit each; 1 = increasing.
- Ball update happens once per frame, on the clock where count_h==0 and count_v==480 (first blank line):
  - Horizontal, dir_h=1: ball_pos_h <= ball_pos_h+1; if ball_pos_h+1 == 624, dir_h <= 0.
  - Horizontal, dir_h=0: ball_pos_h <= ball_pos_h-1; if ball_pos_h-1 == 0, dir_h <= 1.
  - Vertical: same rule with limit 464 using dir_v.
  - The two axes update independently. A corner hit flips both directions in the same update.
  - The ball never leaves the visible area. Position is never drawn mid-update because the update occurs in vertical blank.
- Pixel colouring (combinational from registered state, zero latency):
  - ball = (ball_pos_h <= count_h < ball_pos_h+16) && (ball_pos_v <= count_v < ball_pos_v+16).
  - border = visible && (count_h==0 || count_h==639 || count_v==0 || count_v==479).
  - wht = ~blank && (ball || border).
  - If blank: all 12 colour bits = 0.
  - Else if wht: all 12 colour bits = 1 (white).
  - Else: background dark blue, {r}=0, {g}=0, {b}=4'b0100.
- Reset (rst high at a clock edge):
  - count_h=0, count_v=0.
  - ball_pos_h=312, ball_pos_v=232.
  - dir_h=1, dir_v=1.
  - While rst is high, all colour outputs are forced 0 and hs=vs=1.
  - On the first clock after rst deasserts, the counters start from 0,0. Pixel (0,0) is border, so colours are white.
- Reset mid-frame: counters and ball state return to reset values on the next edge; no partial-frame ball update occurs.
- No other inputs. Outputs are valid every cycle after reset.

Test Plan:
- Reset then run 800 clocks:
  - count_h wraps 799->0 and count_v becomes 1.
  - hs low for exactly 96 clocks, starting at count_h=656.
  - colours are 0 for count_h 640..799.
- Run one full frame (420000 clocks):
  - vs low exactly for lines 490-491, i.e. 1600 clocks.
  - hs pulses 525 times.
  - Frame period is 420000 clocks.
- After reset, sample pixel (0,0): white (all 12 bits 1). Sample pixel (100,100): r=0, g=0, b=4'b0100.
- Ball draw/move:
  - Frame 0: pixels (312..327, 232..247) are white; pixel (328,240) is blue.
  - After the first update at count_v=480: ball_pos_h=313, ball_pos_v=233.
- Bounce: run 312 updates.
  - ball_pos_h reaches 624 and dir_h flips.
  - ball_pos_v reaches 464 after 232 updates (dir_v flips there).
  - The next updates decrement each axis; neither position ever exceeds 624/464 or underflows 0.
- Mid-frame reset, assert rst for 1 clock at count_v=300:
  - Next cycle count_h=0, count_v=0, ball at (312,232).
  - Colours 0 while rst high, white on the following cycle.
